// File: rtl/dclk_monitor.sv
// Divided-clock monitor: synchronizes dclk_in, measures period and high time,
// and tracks lock/fault against an expected period with a timeout watchdog.
module dclk_monitor #(
  parameter int CNT_W      = 28,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dclk_in,
  input  logic             clr,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED,
    FAULT
  } state_t;

  localparam int MW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LCK_C = MW'(LOCK_CNT);

  state_t           state;
  state_t           state_nxt;
  logic             sync0;
  logic             sync1;
  logic             hist;
  logic             rise_ev;
  logic             fall_ev;
  logic             have_rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_nxt;
  logic [CNT_W-1:0] diff;
  logic             in_range;
  logic             timeout;
  logic [MW-1:0]    match;
  logic [MW-1:0]    match_nxt;
  logic [MW-1:0]    match_inc;

  assign rise_ev   = sync1 & ~hist;
  assign fall_ev   = ~sync1 & hist;
  assign cnt_inc   = (cnt == CMAX) ? CMAX : cnt + 1'b1;
  assign match_inc = match + MW'(1);

  always_comb begin
    tcnt_nxt = (tcnt == CMAX) ? CMAX : tcnt + 1'b1;
    if (rise_ev || fall_ev)
      tcnt_nxt = '0;
  end

  assign timeout  = tcnt_nxt > TO_C;
  assign diff     = (period >= EXP_C) ? period - EXP_C : EXP_C - period;
  assign in_range = diff <= TOL_C;

  // FSM judges the registered period while period_valid is high
  always_comb begin
    state_nxt = state;
    match_nxt = match;
    unique case (state)
      IDLE: begin
        if (rise_ev) begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_nxt = FAULT;
        end else if (period_valid) begin
          if (!in_range) begin
            match_nxt = '0;
          end else begin
            match_nxt = match_inc;
            if (match_inc >= LCK_C)
              state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (timeout || (period_valid && !in_range))
          state_nxt = FAULT;
      end
      FAULT: state_nxt = FAULT;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      hist         <= 1'b0;
      rise_tick    <= 1'b0;
      fall_tick    <= 1'b0;
      cnt          <= '0;
      tcnt         <= '0;
      match        <= '0;
      have_rise    <= 1'b0;
      period       <= '0;
      high_cycles  <= '0;
      period_valid <= 1'b0;
      state        <= IDLE;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      sync0        <= dclk_in;
      sync1        <= sync0;
      hist         <= sync1;
      rise_tick    <= rise_ev;
      fall_tick    <= fall_ev;
      state        <= state_nxt;
      match        <= match_nxt;
      locked       <= state_nxt == LOCKED;
      fault        <= state_nxt == FAULT;
      period_valid <= 1'b0;
      if (clr) begin
        cnt       <= '0;
        tcnt      <= '0;
        have_rise <= 1'b0;
      end else begin
        cnt  <= rise_ev ? '0 : cnt_inc;
        tcnt <= tcnt_nxt;
        if (rise_ev) begin
          have_rise <= 1'b1;
          if (have_rise) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
          end
        end
        if (fall_ev && have_rise)
          high_cycles <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_dclk_monitor.sv
// Directed bench for dclk_monitor: lock, period fault, timeout, clear,
// asynchronous reset and a TOL=1 instance.
module tb_dclk_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dclk;
  logic [1:0]  clr;
  logic [1:0]  rt, ft, pv, lk, flt;
  logic [27:0] per0, per1, hc0, hc1;

  int checks = 0;
  int errors = 0;
  int sel, cyc;
  int pv_seen, lock_pv, lock_gap, fault_cyc, fault_gap;
  int last_pv_cyc, last_tick_cyc;
  int exp_per, exp_hi, last_hi, last_lo;
  logic plk, pflt;

  always #5 clk = ~clk;

  dclk_monitor u0 (
    .clk(clk), .rst_n(rst_n), .dclk_in(dclk[0]), .clr(clr[0]),
    .rise_tick(rt[0]), .fall_tick(ft[0]), .period(per0),
    .high_cycles(hc0), .period_valid(pv[0]), .locked(lk[0]),
    .fault(flt[0])
  );

  dclk_monitor #(.TOL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .dclk_in(dclk[1]), .clr(clr[1]),
    .rise_tick(rt[1]), .fall_tick(ft[1]), .period(per1),
    .high_cycles(hc1), .period_valid(pv[1]), .locked(lk[1]),
    .fault(flt[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic reset_mon();
    pv_seen     = 0;
    lock_pv     = -1;
    fault_cyc   = -1;
    fault_gap   = -1;
    last_pv_cyc = cyc;
    plk         = lk[sel];
    pflt        = flt[sel];
  endtask

  task automatic step(input logic v);
    logic p, l, f, t;
    logic [27:0] pr, h;
    dclk[sel] = v;
    @(negedge clk);
    cyc++;
    p  = pv[sel];
    l  = lk[sel];
    f  = flt[sel];
    t  = rt[sel] | ft[sel];
    pr = (sel != 0) ? per1 : per0;
    h  = (sel != 0) ? hc1 : hc0;
    if (p) begin
      pv_seen++;
      last_pv_cyc = cyc;
      check("period", 32'(pr), exp_per);
      check("high_cycles", 32'(h), exp_hi);
    end
    if (t)
      last_tick_cyc = cyc;
    if (l && !plk && lock_pv < 0) begin
      lock_pv  = pv_seen;
      lock_gap = cyc - last_pv_cyc;
    end
    if (f && !pflt && fault_cyc < 0) begin
      fault_cyc = cyc;
      fault_gap = cyc - last_pv_cyc;
    end
    plk  = l;
    pflt = f;
  endtask

  // expected period at this wave's rise is the previous wave's length
  task automatic wave(input int hi, input int lo);
    exp_per = last_hi + last_lo;
    exp_hi  = last_hi;
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
    last_hi = hi;
    last_lo = lo;
  endtask

  initial begin
    dclk = '0;
    clr  = '0;
    sel  = 0;
    cyc  = 0;
    last_hi = 2;
    last_lo = 2;
    last_tick_cyc = 0;
    repeat (3) @(negedge clk);
    check("rst_rise", 32'(rt[0]), 0);
    check("rst_fall", 32'(ft[0]), 0);
    check("rst_pv", 32'(pv[0]), 0);
    check("rst_locked", 32'(lk[0]), 0);
    check("rst_fault", 32'(flt[0]), 0);
    check("rst_period", 32'(per0), 0);
    check("rst_high", 32'(hc0), 0);
    rst_n = 1'b1;

    reset_mon();
    repeat (2) step(1'b0);
    repeat (8) wave(2, 2);
    check("pv_count", pv_seen, 7);
    check("lock_pv", lock_pv, 4);
    check("lock_gap", lock_gap, 1);
    check("locked", 32'(lk[0]), 1);
    check("no_fault", 32'(flt[0]), 0);

    reset_mon();
    wave(3, 3);
    wave(2, 2);
    wave(2, 2);
    check("p6_pv_count", pv_seen, 3);
    check("p6_fault_gap", fault_gap, 1);
    check("p6_fault", 32'(flt[0]), 1);
    check("p6_unlocked", 32'(lk[0]), 0);

    clr[0] = 1'b1;
    step(1'b0);
    clr[0] = 1'b0;
    step(1'b0);
    check("clr_fault", 32'(flt[0]), 0);
    check("clr_locked", 32'(lk[0]), 0);
    check("clr_period_held", 32'(per0), 4);

    reset_mon();
    step(1'b0);
    repeat (6) wave(2, 2);
    check("relock_pv", lock_pv, 4);
    check("relock_gap", lock_gap, 1);
    check("relocked", 32'(lk[0]), 1);

    reset_mon();
    repeat (25) step(1'b0);
    check("to_fault", 32'(flt[0]), 1);
    check("to_gap", fault_cyc - last_tick_cyc, 17);
    check("to_unlocked", 32'(lk[0]), 0);

    clr[0] = 1'b1;
    step(1'b0);
    clr[0] = 1'b0;
    reset_mon();
    repeat (3) wave(2, 2);
    check("meas_pv", pv_seen, 2);
    check("meas_period", 32'(per0), 4);
    check("meas_unlocked", 32'(lk[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", 32'(per0), 0);
    check("arst_high", 32'(hc0), 0);
    check("arst_pv", 32'(pv[0]), 0);
    check("arst_rise", 32'(rt[0]), 0);
    check("arst_fall", 32'(ft[0]), 0);
    check("arst_locked", 32'(lk[0]), 0);
    check("arst_fault", 32'(flt[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 1;
    reset_mon();
    repeat (2) step(1'b0);
    wave(3, 2);
    wave(2, 1);
    wave(2, 2);
    wave(3, 2);
    wave(2, 2);
    check("tol_lock_pv", lock_pv, 4);
    check("tol_lock_gap", lock_gap, 1);
    check("tol_locked", 32'(lk[1]), 1);
    check("tol_no_fault", 32'(flt[1]), 0);
    wave(3, 3);
    wave(2, 2);
    check("tol_fault", 32'(flt[1]), 1);
    check("tol_unlocked", 32'(lk[1]), 0);
    check("tol_fault_gap", fault_gap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dclk_monitor.md
DCLK_MONITOR -- requirements
Module: dclk_monitor

Interface
REQ-001 Parameter CNT_W, default 28: width of all cycle counters and of period/high_cycles (28-bit max counter constraint).
REQ-002 Parameter EXP_PERIOD, default 4: expected dclk period in clk cycles.
REQ-003 Parameter TOL, default 0: allowed absolute deviation from EXP_PERIOD, in clk cycles.
REQ-004 Parameter LOCK_CNT, default 4: consecutive in-range periods required to lock.
REQ-005 Parameter TIMEOUT, default 16: maximum clk cycles allowed between dclk edge events.
REQ-006 clk  input  1  single system clock; all logic on posedge clk.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 dclk_in  input  1  divided-clock signal, asynchronous to clk, treated as data.
REQ-009 clr  input  1  synchronous fault clear, single-cycle pulse.
REQ-010 rise_tick  output  1  one-cycle pulse per synchronized dclk rising edge.
REQ-011 fall_tick  output  1  one-cycle pulse per synchronized dclk falling edge.
REQ-012 period  output  CNT_W  last measured rise-to-rise interval, in clk cycles.
REQ-013 high_cycles  output  CNT_W  last measured rise-to-fall interval, in clk cycles.
REQ-014 period_valid  output  1  one-cycle pulse when period updates.
REQ-015 locked  output  1  high while in LOCKED.
REQ-016 fault  output  1  high while in FAULT.

Function
REQ-017 dclk_in SHALL pass through a 2-flop synchronizer plus one history flop; edges SHALL be detected from synchronized vs history value only.
REQ-018 Latency: dclk_in sampled 1 at edge N after 0 at N-1 -> rise_tick high for exactly the cycle following edge N+2; fall_tick symmetric.
REQ-019 All outputs SHALL be registered.
REQ-020 Interval counter: cleared to 0 in a rise_tick cycle, +1 every other cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-021 On every rise_tick except the first after IDLE: period <= counter+1 (saturating), period_valid pulses the same cycle as rise_tick.
REQ-022 On fall_tick with a prior rise since IDLE: high_cycles <= counter+1 (saturating); fall before any rise ignored.
REQ-023 In-range: |period - EXP_PERIOD| <= TOL, compared without overflow at full CNT_W.
REQ-024 Timeout counter: cleared on any rise_tick/fall_tick, +1 otherwise, saturating; timeout event when value exceeds TIMEOUT.
REQ-025 FSM states: IDLE, MEASURE, LOCKED, FAULT; encoding free.
REQ-026 IDLE: first rise_tick -> MEASURE, match count <= 0; no timeout checking in IDLE.
REQ-027 MEASURE: in-range period -> match count +1; reaching LOCK_CNT -> LOCKED; out-of-range -> match count 0, stay; timeout -> FAULT.
REQ-028 LOCKED: out-of-range period or timeout -> FAULT.
REQ-029 FAULT: sticky; period/high_cycles keep updating; clr -> IDLE.
REQ-030 clr in IDLE/MEASURE/LOCKED -> IDLE, counters and match count cleared, period/high_cycles held.
REQ-031 clr coincident with a fault condition: clr wins, next state IDLE.
REQ-032 Out-of-range and timeout in the same cycle: single transition to FAULT.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, synchronizer/history flops 0, all counters 0, period 0, high_cycles 0, all pulse outputs 0, locked 0, fault 0.
REQ-034 Reset deassertion mid-dclk-high SHALL NOT produce a rise_tick until a fresh 0->1 transition after the synchronizer reads 0 (history starts 0, so a rise_tick may occur once; it counts as the first rise and yields no period).

Verification
REQ-035 dclk_in = clk/4 square wave (2 high, 2 low), defaults -> period=4, high_cycles=2 on every update; locked=1 in the cycle after the 4th period_valid.
REQ-036 Locked, then one period of 6 -> period=6 with period_valid; fault=1 and locked=0 next cycle.
REQ-037 Locked, dclk_in held constant -> fault=1 on the cycle timeout counter reaches 17.
REQ-038 Fault, clr pulse -> IDLE (locked=0, fault=0); resumed clk/4 input relocks after 4 more periods.
REQ-039 TOL=1, periods 5,3,4,5 -> locks; period 6 -> fault.
REQ-040 rst_n asserted mid-MEASURE -> all outputs 0 immediately, without waiting for a clk edge.
